// File: rtl/wrapper_sched_pkg.sv
// Shared types and sizing helpers for the wrapper packet scheduler.
// Word width matches the AHB data register feeding the constructor.
package wrapper_sched_pkg;

   localparam int REGDWIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } sched_state_t;

   function automatic int words(input int packetwidth);
      return packetwidth / REGDWIDTH;
   endfunction

endpackage

// File: rtl/wrapper_rr_arbiter.sv
// Round-robin pick: lowest requesting index at or after ptr, wrapping.
// Purely combinational; the owner of ptr lives in the scheduler.
module wrapper_rr_arbiter #(
   parameter int NUM_CH = 2
) (
   input  logic [NUM_CH-1:0]         req,
   input  logic [$clog2(NUM_CH)-1:0] ptr,
   output logic [NUM_CH-1:0]         grant,
   output logic [$clog2(NUM_CH)-1:0] idx,
   output logic                      valid
);

   localparam int PW = $clog2(NUM_CH);

   always_comb begin
      int            sel;
      logic [PW-1:0] s;
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      sel   = 0;
      s     = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         sel = int'(ptr) + k;
         if (sel >= NUM_CH) sel = sel - NUM_CH;
         s = PW'(sel);
         if (!valid && req[s]) begin
            valid    = 1'b1;
            grant[s] = 1'b1;
            idx      = s;
         end
      end
   end

endmodule

// File: rtl/wrapper_packet_scheduler.sv
// Grants the shared packet constructor to one requester per packet,
// round-robin, counting accepted words and aborting on a stalled owner.
module wrapper_packet_scheduler
   import wrapper_sched_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int PACKETWIDTH = 512,
   parameter int TIMEOUT     = 1024
) (
   input  logic                                  hclk,
   input  logic                                  hreset,
   input  logic [NUM_CH-1:0]                     ch_req,
   input  logic                                  constructor_ready,
   input  logic                                  word_xfer,
   output logic [NUM_CH-1:0]                     ch_grant,
   output logic [NUM_CH-1:0]                     data_req,
   output logic [NUM_CH-1:0]                     ch_done,
   output logic [NUM_CH-1:0]                     ch_abort,
   output logic                                  busy,
   output logic [$clog2(words(PACKETWIDTH))-1:0] word_cnt
);

   localparam int WORDS = words(PACKETWIDTH);
   localparam int CW    = $clog2(WORDS);
   localparam int PW    = $clog2(NUM_CH);
   localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
   localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [PW-1:0] PMAX = PW'(NUM_CH - 1);

   sched_state_t      state;
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     owner;
   logic [PW-1:0]     next_ptr;
   logic [PW-1:0]     arb_idx;
   logic [NUM_CH-1:0] arb_grant;
   logic              arb_valid;
   logic [TW-1:0]     timer;
   logic              last_seen;
   logic              timed_out;

   wrapper_rr_arbiter #(
      .NUM_CH(NUM_CH)
   ) u_arb (
      .req  (ch_req),
      .ptr  (rr_ptr),
      .grant(arb_grant),
      .idx  (arb_idx),
      .valid(arb_valid)
   );

   // Last word's address phase is already out once the count hits WORDS-1.
   assign last_seen = (word_cnt == LAST);
   assign data_req  = ch_grant & {NUM_CH{constructor_ready & ~last_seen}};
   assign timed_out = (TIMEOUT != 0) && (timer == TLIM);
   assign next_ptr  = (owner == PMAX) ? '0 : owner + 1'b1;

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state    <= IDLE;
         ch_grant <= '0;
         ch_done  <= '0;
         ch_abort <= '0;
         busy     <= 1'b0;
         word_cnt <= '0;
         rr_ptr   <= '0;
         owner    <= '0;
         timer    <= '0;
      end else begin
         ch_done  <= '0;
         ch_abort <= '0;
         unique case (state)
            IDLE: begin
               if (arb_valid && constructor_ready) begin
                  ch_grant <= arb_grant;
                  owner    <= arb_idx;
                  word_cnt <= '0;
                  timer    <= '0;
                  busy     <= 1'b1;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (word_xfer) begin
                  word_cnt <= word_cnt + 1'b1;
                  timer    <= '0;
                  if (last_seen) begin
                     ch_done  <= ch_grant;
                     ch_grant <= '0;
                     rr_ptr   <= next_ptr;
                     state    <= DONE;
                  end
               end else if (timed_out) begin
                  ch_abort <= ch_grant;
                  ch_grant <= '0;
                  rr_ptr   <= next_ptr;
                  word_cnt <= '0;
                  timer    <= '0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
